// File: rtl/core_pkg.sv
// core_pkg: shared front-end constants and fetch state encoding.
// Contents: reset/trap vectors, NOP encoding and the fetch FSM state type.
package core_pkg;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;
endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// fetch_sequencer_pc_reg: program counter register with load enable.
// Ports: i_clk, i_rst_n (async, active low), i_load, i_next_pc -> o_pc.
module fetch_sequencer_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic [31:0] i_next_pc,
    output logic [31:0] o_pc
);
    logic [31:0] r_pc;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_pc <= RESET_PC;
        else if (i_load) r_pc <= i_next_pc;
    assign o_pc = r_pc;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC selection, single-outstanding imem fetch and one-entry decode buffer.
// Ports: i_clk, i_rst_n; imem request (o_imem_req_valid/addr, i_imem_req_ready);
// imem response (i_imem_rsp_valid/data); i_redirect_valid/pc, i_trap_valid;
// decode side (o_id_valid/instr/pc, i_id_ready); o_pc, o_fetch_misalign.
module fetch_sequencer
    import core_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_trap_valid,
    output logic        o_id_valid,
    input  logic        i_id_ready,
    output logic [31:0] o_id_instr,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_pc,
    output logic        o_fetch_misalign
);
    fetch_state_t r_state;
    logic         r_stale, r_buf_valid, r_misalign;
    logic [31:0]  r_req_pc, r_buf_instr, r_buf_pc;
    logic         w_flush, w_misaligned, w_hs, w_write;
    logic [31:0]  w_pc, w_next_pc;

    assign w_flush      = i_redirect_valid | i_trap_valid;
    assign w_misaligned = i_redirect_valid & ~i_trap_valid & (i_redirect_pc[1:0] != 2'b00);
    // A new request is offered only if the buffer can take its response.
    assign o_imem_req_valid = (r_state == REQ) & (~r_buf_valid | i_id_ready);
    assign w_hs      = o_imem_req_valid & i_imem_req_ready;
    assign w_write   = (r_state == WAIT) & i_imem_rsp_valid & ~r_stale & ~w_flush;
    assign w_next_pc = (i_trap_valid | w_misaligned) ? TRAP_VEC :
                       i_redirect_valid ? i_redirect_pc : w_pc + 32'd4;

    fetch_sequencer_pc_reg #(.RESET_PC(RESET_PC)) pc_reg (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (w_flush | w_hs),
        .i_next_pc (w_next_pc),
        .o_pc      (w_pc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_stale     <= 1'b0;
            r_req_pc    <= '0;
            r_buf_valid <= 1'b0;
            r_buf_instr <= '0;
            r_buf_pc    <= '0;
            r_misalign  <= 1'b0;
        end else begin
            r_misalign <= w_misaligned;
            case (r_state)
                IDLE: r_state <= REQ;
                REQ: if (w_hs) begin
                    r_state  <= WAIT;
                    r_req_pc <= w_pc;
                    r_stale  <= w_flush;
                end
                // A response arriving with a redirect is dropped here, so stale never outlives it.
                WAIT: if (i_imem_rsp_valid) begin
                    r_state <= REQ;
                    r_stale <= 1'b0;
                end else if (w_flush) r_stale <= 1'b1;
                default: r_state <= IDLE;
            endcase
            if (w_flush) r_buf_valid <= 1'b0;
            else if (w_write) begin
                r_buf_valid <= 1'b1;
                r_buf_instr <= i_imem_rsp_data;
                r_buf_pc    <= r_req_pc;
            end else if (r_buf_valid & i_id_ready) r_buf_valid <= 1'b0;
        end
    end

    assign o_imem_req_addr  = w_pc;
    assign o_pc             = w_pc;
    assign o_id_valid       = r_buf_valid;
    assign o_id_instr       = r_buf_instr;
    assign o_id_pc          = r_buf_pc;
    assign o_fetch_misalign = r_misalign;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and random checks of fetch_sequencer against a transaction-level model.
module tb_fetch_sequencer;
    import core_pkg::*;
    logic        i_clk = 1'b0, i_rst_n = 1'b0;
    logic        o_imem_req_valid, i_imem_req_ready = 1'b0;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid = 1'b0;
    logic [31:0] i_imem_rsp_data = '0;
    logic        i_redirect_valid = 1'b0, i_trap_valid = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_id_valid, i_id_ready = 1'b0;
    logic [31:0] o_id_instr, o_id_pc, o_pc;
    logic        o_fetch_misalign;

    always #5 i_clk = ~i_clk;

    fetch_sequencer dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .o_imem_req_valid(o_imem_req_valid), .i_imem_req_ready(i_imem_req_ready),
        .o_imem_req_addr(o_imem_req_addr),
        .i_imem_rsp_valid(i_imem_rsp_valid), .i_imem_rsp_data(i_imem_rsp_data),
        .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
        .i_trap_valid(i_trap_valid),
        .o_id_valid(o_id_valid), .i_id_ready(i_id_ready),
        .o_id_instr(o_id_instr), .o_id_pc(o_id_pc),
        .o_pc(o_pc), .o_fetch_misalign(o_fetch_misalign)
    );

    int vectors = 0, miscompares = 0;
    // model: next fetch address, one outstanding fetch, one buffered instruction
    logic [31:0] m_pc, m_oaddr, m_bpc;
    bit          m_boot, m_out, m_live, m_bv, m_mis;
    // memory stimulus
    bit          mem_pend;
    int          mem_cnt, lat = 1;
    logic [31:0] mem_addr;
    // last sampled outputs
    logic        s_rv, s_hs, s_idv, s_mis;
    logic [31:0] s_addr, s_pc, s_idpc, s_idinstr;
    logic [31:0] req_log[$], id_log[$];
    bit          saw8 = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ NOP_INSTR;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_boot = 1; m_out = 0; m_live = 0; m_bv = 0; m_mis = 0;
        mem_pend = 0; mem_cnt = 0;
    endtask

    task automatic reset_checks(input string p);
        chk({p, "_pc"}, o_pc, RESET_PC);
        chk({p, "_req_addr"}, o_imem_req_addr, RESET_PC);
        chk({p, "_req_valid"}, o_imem_req_valid, 0);
        chk({p, "_id_valid"}, o_id_valid, 0);
        chk({p, "_id_instr"}, o_id_instr, 0);
        chk({p, "_id_pc"}, o_id_pc, 0);
        chk({p, "_misalign"}, o_fetch_misalign, 0);
    endtask

    task automatic cycle();
        logic exp_rv, flush, mhs;
        i_imem_rsp_valid = mem_pend && mem_cnt == 1;
        i_imem_rsp_data  = i_imem_rsp_valid ? memf(mem_addr) : $urandom;
        #4;
        s_rv = o_imem_req_valid; s_addr = o_imem_req_addr; s_pc = o_pc;
        s_idv = o_id_valid; s_idpc = o_id_pc; s_idinstr = o_id_instr; s_mis = o_fetch_misalign;
        s_hs = s_rv & i_imem_req_ready;
        exp_rv = !m_boot && !m_out && (!m_bv || i_id_ready);
        chk("pc", s_pc, m_pc);
        chk("req_addr", s_addr, m_pc);
        chk("req_valid", s_rv, exp_rv);
        chk("id_valid", s_idv, m_bv);
        if (m_bv) begin
            chk("id_pc", s_idpc, m_bpc);
            chk("id_instr", s_idinstr, memf(m_bpc));
        end
        chk("misalign", s_mis, m_mis);
        if (s_hs) req_log.push_back(s_addr);
        if (s_idv && i_id_ready) id_log.push_back(s_idpc);
        if (s_idv && s_idpc == 32'h8) saw8 = 1;
        if (i_imem_rsp_valid) mem_pend = 0;
        else if (mem_pend) mem_cnt--;
        if (s_hs) begin mem_pend = 1; mem_cnt = lat; mem_addr = s_addr; end
        flush = i_redirect_valid | i_trap_valid;
        mhs = exp_rv & i_imem_req_ready;
        if (flush || (m_bv && i_id_ready)) m_bv = 0;
        if (m_out && i_imem_rsp_valid) begin
            m_out = 0;
            if (m_live && !flush) begin m_bv = 1; m_bpc = m_oaddr; end
        end
        if (flush) m_live = 0;
        if (mhs) begin m_out = 1; m_live = !flush; m_oaddr = m_pc; end
        m_mis = i_redirect_valid && !i_trap_valid && i_redirect_pc[1:0] != 2'b00;
        m_pc = (i_trap_valid || m_mis) ? TRAP_VEC : i_redirect_valid ? i_redirect_pc :
               mhs ? m_pc + 32'd4 : m_pc;
        m_boot = 0;
        @(negedge i_clk);
        i_redirect_valid = 0; i_trap_valid = 0;
    endtask

    task automatic run_to_req(input string tag, input logic [31:0] exp, input int max);
        int n = 0;
        do begin cycle(); n++; end while (!s_hs && n < max);
        chk({tag, "_hs"}, s_hs, 1);
        chk(tag, s_addr, exp);
    endtask

    initial begin
        logic [31:0] t;
        int r;
        model_reset();
        #3 reset_checks("reset");
        @(negedge i_clk);
        i_rst_n = 1; i_imem_req_ready = 1; i_id_ready = 1; lat = 1;
        repeat (5) cycle();
        i_id_ready = 0;
        repeat (5) begin
            cycle();
            chk("stall_req_valid", s_rv, 0);
            chk("stall_id_pc", s_idpc, 32'h4);
            chk("stall_id_instr", s_idinstr, memf(32'h4));
        end
        i_id_ready = 1; lat = 2;
        cycle();
        chk("release_req_valid", s_rv, 1);
        chk("release_req_addr", s_addr, 32'h8);
        chk("req_count", req_log.size(), 3);
        chk("req0", req_log[0], 32'h0);
        chk("req1", req_log[1], 32'h4);
        chk("req2", req_log[2], 32'h8);
        chk("id_count", id_log.size(), 2);
        chk("id0", id_log[0], 32'h0);
        chk("id1", id_log[1], 32'h4);
        i_redirect_valid = 1; i_redirect_pc = 32'h200;
        cycle();
        lat = 1;
        run_to_req("redir_req", 32'h200, 8);
        chk("no_pc8", saw8, 0);
        i_trap_valid = 1; i_redirect_valid = 1; i_redirect_pc = 32'h300;
        cycle();
        run_to_req("trap_req", TRAP_VEC, 8);
        chk("trap_pc", s_pc, TRAP_VEC);
        i_redirect_valid = 1; i_redirect_pc = 32'h202;
        cycle();
        cycle();
        chk("mis_pulse", s_mis, 1);
        chk("mis_hs", s_hs, 1);
        chk("mis_addr", s_addr, TRAP_VEC);
        i_redirect_valid = 1; i_redirect_pc = 32'hFFFF_FFFC;
        cycle();
        chk("mis_clear", s_mis, 0);
        lat = 3;
        run_to_req("wrap_req", 32'hFFFF_FFFC, 8);
        cycle();
        chk("wrap_pc", s_pc, 32'h0);
        #2 i_rst_n = 0;
        #1 reset_checks("midreset");
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1; lat = 1;
        run_to_req("restart", RESET_PC, 5);
        repeat (400) begin
            i_imem_req_ready = $urandom_range(0, 3) != 0;
            i_id_ready = $urandom_range(0, 4) < 3;
            lat = $urandom_range(1, 3);
            r = $urandom_range(0, 99);
            if (r < 10) begin
                t = $urandom;
                if (r >= 3) t[1:0] = 2'b00;
                i_redirect_valid = 1; i_redirect_pc = t;
            end else if (r < 14) i_trap_valid = 1;
            cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
